// File: rtl/boot_pkg.sv
// Shared encodings and widths for the instruction-memory boot loader.
package boot_pkg;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CSUM_W = 8;

    localparam logic [2:0] ST_LEN_LO  = 3'd0;
    localparam logic [2:0] ST_LEN_HI  = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

endpackage

// File: rtl/boot_word_packer.sv
// Collects four stream bytes into a little-endian 32-bit word; flags the byte
// that completes the word so the caller can write it on the same edge.
module boot_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] buf_q, buf_d;

    always_comb begin
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        word_done = byte_valid && (cnt_q == 2'd3);
        // The completing byte lands in the top lane without passing through the buffer.
        word      = {byte_in, buf_q};
        if (byte_valid) begin
            cnt_d = cnt_q + 2'd1;
            buf_d = {byte_in, buf_q[23:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the core
// in reset until done. BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
import boot_pkg::*;

module imem_boot_loader #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    logic [2:0]       state_q, state_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] hdr_len;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             core_rst_q, core_rst_d;
    logic             accept, pack_valid, word_done;
    logic [31:0]      word;
    logic [2:0]       st_after_len;
`ifdef BOOT_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;
`endif

`ifdef BOOT_CHECKSUM_EN
    assign st_after_len = ST_CHECK;
`else
    assign st_after_len = ST_DONE;
`endif

    assign in_ready   = !rst && (state_q == ST_LEN_LO || state_q == ST_LEN_HI ||
                                 state_q == ST_PAYLOAD || state_q == ST_CHECK);
    assign accept     = in_valid && in_ready;
    assign pack_valid = accept && (state_q == ST_PAYLOAD);
    assign hdr_len    = {in_data, len_lo_q};

    boot_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (pack_valid),
        .byte_in    (in_data),
        .word_done  (word_done),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        if (word_done) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {{(32-LEN_W-2){1'b0}}, idx_q, 2'b00};
            mem_wdata_d = word;
            idx_d       = idx_q + LEN_W'(1);
        end
        case (state_q)
            ST_LEN_LO: begin
                idx_d = '0;
`ifdef BOOT_CHECKSUM_EN
                csum_d = '0;
`endif
                if (accept) begin
                    len_lo_d = in_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d = hdr_len;
                    if (32'(hdr_len) > DEPTH_WORDS)
                        state_d = ST_ERR;
                    else if (hdr_len == '0)
                        state_d = st_after_len;
                    else
                        state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
`ifdef BOOT_CHECKSUM_EN
                if (pack_valid)
                    csum_d = csum_q ^ in_data;
`endif
                if (word_done && (idx_q == len_q - LEN_W'(1)))
                    state_d = st_after_len;
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHECK: begin
                if (accept)
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = state_q;
        endcase
        // Status flags follow the next state so they rise together with the last write.
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
        core_rst_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LEN_LO;
            len_lo_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            core_rst_q  <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            core_rst_q  <= core_rst_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign core_rst  = core_rst_q;

endmodule
